// File: rtl/record_fifo_pkg.sv
// Shared types, default sizes and width helpers for the byte-to-record FIFO.
package record_fifo_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned RECORD_SIZE_BYTES_DEFAULT = 16;
  localparam int unsigned SLOTS_DEFAULT             = 32;

  // Pointer width for a slot array of the given depth.
  function automatic int unsigned ptr_width(input int unsigned slots);
    return (slots > 1) ? int'($clog2(slots)) : 1;
  endfunction

  // Level counter needs one extra bit to represent a completely full array.
  function automatic int unsigned level_width(input int unsigned slots);
    return ptr_width(slots) + 1;
  endfunction

endpackage

// File: rtl/record_fifo_if.sv
// Byte input / record output handshake bundle of the record FIFO.
interface record_fifo_if
  import record_fifo_pkg::*;
#(
  parameter int unsigned RECORD_SIZE_BYTES = RECORD_SIZE_BYTES_DEFAULT,
  parameter int unsigned SLOTS             = SLOTS_DEFAULT
);
  localparam int unsigned REC_W = RECORD_SIZE_BYTES * 8;
  localparam int unsigned LVL_W = level_width(SLOTS);

  byte_t              in_byte;
  logic               in_valid;
  logic               in_ready;
  logic               in_abort;
  logic               out_valid;
  logic               out_ready;
  logic [REC_W-1:0]   out_record;
  logic [LVL_W-1:0]   level;
  logic               almost_full;

  // Producer of bytes and consumer of records.
  modport master (
    output in_byte, in_valid, in_abort, out_ready,
    input  in_ready, out_valid, out_record, level, almost_full
  );

  // The FIFO itself.
  modport slave (
    input  in_byte, in_valid, in_abort, out_ready,
    output in_ready, out_valid, out_record, level, almost_full
  );

endinterface

// File: rtl/record_assembler.sv
// Places accepted bytes into a record register and strobes commit on the last byte.
module record_assembler
  import record_fifo_pkg::*;
#(
  parameter int unsigned RECORD_SIZE_BYTES = RECORD_SIZE_BYTES_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  byte_t                          byte_i,
  input  logic                           accept_i,
  input  logic                           abort_i,
  output logic                           commit_c_o,
  output logic [RECORD_SIZE_BYTES*8-1:0] record_c_o,
  output logic                           last_next_c_o
);

  localparam int unsigned IDX_W = (RECORD_SIZE_BYTES > 1) ? $clog2(RECORD_SIZE_BYTES) : 1;
  localparam int unsigned REC_W = RECORD_SIZE_BYTES * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_SIZE_BYTES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic             commit;

  // Abort beats a same-cycle byte, so an aborted final byte never commits.
  always_comb begin
    idx_d  = idx_q;
    rec_d  = rec_q;
    commit = 1'b0;
    if (abort_i) begin
      idx_d = '0;
    end else if (accept_i) begin
      rec_d[{idx_q, 3'b000} +: 8] = byte_i;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        commit = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Index and partial record storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      rec_q <= '0;
    end else begin
      idx_q <= idx_d;
      rec_q <= rec_d;
    end
  end

  assign commit_c_o    = commit;
  assign record_c_o    = rec_d;
  assign last_next_c_o = (idx_d == LAST_IDX);

endmodule

// File: rtl/record_fifo.sv
// Byte-to-record packing FIFO: assembler feeding a circular array of record slots.
module record_fifo
  import record_fifo_pkg::*;
#(
  parameter int unsigned RECORD_SIZE_BYTES = RECORD_SIZE_BYTES_DEFAULT,
  parameter int unsigned SLOTS             = SLOTS_DEFAULT,
  parameter int unsigned ALMOST_FULL       = SLOTS - 4
) (
  input  logic          clk,
  input  logic          rst,
  record_fifo_if.slave  bus
);

  localparam int unsigned REC_W = RECORD_SIZE_BYTES * 8;
  localparam int unsigned PTR_W = ptr_width(SLOTS);
  localparam int unsigned LVL_W = level_width(SLOTS);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(SLOTS);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(ALMOST_FULL);

  logic             accept, push, pop, last_next;
  logic [REC_W-1:0] commit_rec;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             af_q, af_d;
  logic [REC_W-1:0] mem_q [SLOTS];

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = out_valid_q && bus.out_ready;

  record_assembler #(
    .RECORD_SIZE_BYTES (RECORD_SIZE_BYTES)
  ) u_assembler (
    .clk           (clk),
    .rst           (rst),
    .byte_i        (bus.in_byte),
    .accept_i      (accept),
    .abort_i       (bus.in_abort),
    .commit_c_o    (push),
    .record_c_o    (commit_rec),
    .last_next_c_o (last_next)
  );

  // Pointer/count update; flags are precomputed from next state so they stay registered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    in_ready_d  = !(last_next && (count_d == FULL_LVL));
    out_valid_d = (count_d != '0);
    af_d        = (count_d >= AF_LVL);
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      af_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      af_q        <= af_d;
    end
  end

  // Slot array write on commit; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= commit_rec;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_record  = out_valid_q ? mem_q[rd_ptr_q] : '0;
  assign bus.level       = count_q;
  assign bus.almost_full = af_q;

endmodule

// File: tb/tb_record_fifo.sv
// Scoreboard bench for record_fifo: bytes are modelled into records at the input, compared on pop.
module tb_record_fifo;
  import record_fifo_pkg::*;

  localparam int unsigned RSB   = 16;
  localparam int unsigned SLOTS = 32;
  localparam int unsigned AF    = SLOTS - 4;
  localparam int unsigned REC_W = RSB * 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  record_fifo_if #(.RECORD_SIZE_BYTES(RSB), .SLOTS(SLOTS)) bus ();

  record_fifo #(
    .RECORD_SIZE_BYTES (RSB),
    .SLOTS             (SLOTS),
    .ALMOST_FULL       (AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [REC_W-1:0] sb [$];
  logic [REC_W-1:0] asm_rec = '0;
  int asm_n = 0;

  task automatic check_val(input string tag, input logic [REC_W-1:0] act,
                           input logic [REC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor away from the active edge: check flags, compare pops, model accepted bytes.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      asm_n = 0;
    end else begin
      check_val("level", REC_W'(bus.level), REC_W'(sb.size()));
      check_val("out_valid", REC_W'(bus.out_valid), REC_W'(sb.size() != 0));
      check_val("almost_full", REC_W'(bus.almost_full), REC_W'(sb.size() >= int'(AF)));
      check_val("in_ready", REC_W'(bus.in_ready),
                REC_W'(!(asm_n == int'(RSB) - 1 && sb.size() == int'(SLOTS))));
      if (!bus.out_valid) begin
        check_val("out_record_idle", bus.out_record, '0);
      end else if (bus.out_ready && sb.size() != 0) begin
        check_val("out_record", bus.out_record, sb[0]);
        void'(sb.pop_front());
      end
      if (bus.in_abort) begin
        asm_n = 0;
      end else if (bus.in_valid && bus.in_ready) begin
        asm_rec[asm_n*8 +: 8] = bus.in_byte;
        asm_n++;
        if (asm_n == int'(RSB)) begin
          sb.push_back(asm_rec);
          asm_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte_t b);
    int t;
    t = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 200) begin
      step();
      t++;
    end
    if (!bus.in_ready) check_val("send_timeout", REC_W'(bus.in_ready), REC_W'(1'b1));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_record(input logic [REC_W-1:0] r);
    for (int i = 0; i < int'(RSB); i++) send_byte(r[i*8 +: 8]);
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r;
    for (int i = 0; i < int'(REC_W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while (bus.level != '0 && t < 200) begin
      step();
      t++;
    end
    bus.out_ready = 1'b0;
    check_val("drain_level", REC_W'(bus.level), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [REC_W-1:0] r;
    bus.in_byte   = '0;
    bus.in_valid  = 1'b0;
    bus.in_abort  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset values
    check_val("rst_in_ready", REC_W'(bus.in_ready), REC_W'(1'b1));
    check_val("rst_out_valid", REC_W'(bus.out_valid), '0);
    check_val("rst_out_record", bus.out_record, '0);
    check_val("rst_level", REC_W'(bus.level), '0);
    check_val("rst_almost_full", REC_W'(bus.almost_full), '0);

    // First record 0x00..0x0F, visible the cycle after the final byte
    for (int i = 0; i < 15; i++) send_byte(byte_t'(i));
    check_val("t1_not_yet_valid", REC_W'(bus.out_valid), '0);
    send_byte(8'h0F);
    check_val("t1_out_valid", REC_W'(bus.out_valid), REC_W'(1'b1));
    check_val("t1_out_record", bus.out_record, 128'h0F0E0D0C0B0A09080706050403020100);
    check_val("t1_level", REC_W'(bus.level), REC_W'(1));
    drain();

    // Fill all slots, stall on the final byte of record 33, release with one pop
    for (int k = 0; k < int'(SLOTS); k++) begin
      send_record(rand_rec());
      if (k == int'(AF) - 2) check_val("t2_af_below", REC_W'(bus.almost_full), '0);
      if (k == int'(AF) - 1) check_val("t2_af_at", REC_W'(bus.almost_full), REC_W'(1'b1));
    end
    check_val("t2_level_full", REC_W'(bus.level), REC_W'(SLOTS));
    check_val("t2_af_full", REC_W'(bus.almost_full), REC_W'(1'b1));
    r = rand_rec();
    for (int i = 0; i < int'(RSB) - 1; i++) send_byte(r[i*8 +: 8]);
    bus.in_byte  = r[REC_W-8 +: 8];
    bus.in_valid = 1'b1;
    repeat (3) step();
    check_val("t2_stall", REC_W'(bus.in_ready), '0);
    check_val("t2_stall_level", REC_W'(bus.level), REC_W'(SLOTS));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_val("t2_ready_after_pop", REC_W'(bus.in_ready), REC_W'(1'b1));
    step();
    bus.in_valid = 1'b0;
    check_val("t2_level_after_commit", REC_W'(bus.level), REC_W'(SLOTS));
    drain();

    // Abort with a same-cycle byte, then one clean record
    for (int i = 0; i < 5; i++) send_byte(byte_t'(8'h10 + i));
    bus.in_byte  = 8'h55;
    bus.in_valid = 1'b1;
    bus.in_abort = 1'b1;
    step();
    bus.in_abort = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(RSB); i++) send_byte(byte_t'(8'hA0 + i));
    check_val("t3_level", REC_W'(bus.level), REC_W'(1));
    check_val("t3_record", bus.out_record, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    repeat (3) step();
    check_val("t3_level_stable", REC_W'(bus.level), REC_W'(1));
    drain();

    // Streaming at level 1 with commit and pop on the same edge, across pointer wrap
    send_record(rand_rec());
    for (int k = 0; k < 40; k++) begin
      r = rand_rec();
      for (int i = 0; i < int'(RSB) - 1; i++) send_byte(r[i*8 +: 8]);
      bus.out_ready = 1'b1;
      send_byte(r[REC_W-8 +: 8]);
      bus.out_ready = 1'b0;
      check_val("t4_level", REC_W'(bus.level), REC_W'(1));
    end
    drain();

    // Asynchronous reset mid-record with three records stored
    for (int k = 0; k < 3; k++) send_record(rand_rec());
    for (int i = 0; i < 7; i++) send_byte(byte_t'(8'h30 + i));
    check_val("t5_level_pre", REC_W'(bus.level), REC_W'(3));
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("t5_out_valid", REC_W'(bus.out_valid), '0);
    check_val("t5_out_record", bus.out_record, '0);
    check_val("t5_level", REC_W'(bus.level), '0);
    check_val("t5_in_ready", REC_W'(bus.in_ready), REC_W'(1'b1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    r = rand_rec();
    send_record(r);
    check_val("t5_fresh_valid", REC_W'(bus.out_valid), REC_W'(1'b1));
    check_val("t5_fresh_record", bus.out_record, r);
    check_val("t5_fresh_level", REC_W'(bus.level), REC_W'(1));
    drain();

    step();
    check_val("scoreboard_empty", REC_W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
